// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline stall/flush controller.
package pipeline_hazard_ctrl_pkg;

   typedef enum logic [1:0] {RUN, STALL, DEFER, HALT} ctrl_state_t;

   localparam int DEF_STAGES = 6;
   localparam int MAX_STAGES = 32;
   localparam int STAGE_PC   = 0;
   localparam int STAGE_WB   = DEF_STAGES - 1;

   // Low-inclusive mask: bits 0..idx set, clipped to the pipeline depth.
   function automatic logic [MAX_STAGES-1:0] thermo(input int idx, input int stages);
      logic [MAX_STAGES-1:0] m;
      m = '0;
      for (int k = 0; k < MAX_STAGES; k++)
         if (k <= idx && k < stages) m[k] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Request/enable bundle between the pipeline and its hazard controller.
interface pipeline_hazard_ctrl_if #(
   parameter int STAGES = 6,
   parameter int CNT_W  = 32
);
   logic              rdy;
   logic [STAGES-1:0] stall_req;
   logic [STAGES-1:0] flush_req;
   logic [STAGES-1:0] stall;
   logic [STAGES-1:0] flush;
   logic              flush_pending;
   logic              stall_timeout;
   logic [CNT_W-1:0]  stall_cycles;

   modport master (
      output rdy, stall_req, flush_req,
      input  stall, flush, flush_pending, stall_timeout, stall_cycles
   );

   modport slave (
      input  rdy, stall_req, flush_req,
      output stall, flush, flush_pending, stall_timeout, stall_cycles
   );
endinterface

// File: rtl/pipeline_hazard_ctrl_prio_enc_hi.sv
// Highest-set-bit encoder: index of the oldest requesting stage plus a valid flag.
module prio_enc_hi #(
   parameter int N     = 6,
   parameter int IDX_W = 3
) (
   input  logic [N-1:0]     vec,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (vec[i]) begin
            idx   = IDX_W'(i);
            valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller: thermometer stalls, deferred merged flushes,
// stall watchdog and a saturating stall-cycle statistic.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int STAGES  = 6,
   parameter int STG_W   = 3,
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 32
) (
   input logic                  clk,
   input logic                  rst,
   pipeline_hazard_ctrl_if.slave bus
);
   localparam int WD_W = $clog2(TIMEOUT + 1);

   logic [STG_W-1:0]      s_idx, f_idx, e_idx;
   logic                  s_valid, f_valid, e_valid, apply;
   logic [STAGES-1:0]     flush_src;
   logic [MAX_STAGES-1:0] s_therm, e_therm;

   logic                  pend_valid, pend_valid_nxt;
   logic [STG_W-1:0]      pend_idx, pend_idx_nxt;
   ctrl_state_t           cur_state;

   logic [WD_W-1:0]       wd_cnt;
   logic                  timeout_q;
   logic [CNT_W-1:0]      cyc_q;

   // Stage 0 is the PC; it never receives a flush request.
   assign flush_src = {bus.flush_req[STAGES-1:1], 1'b0};

   prio_enc_hi #(.N(STAGES), .IDX_W(STG_W)) u_stall_enc (
      .vec(bus.stall_req), .idx(s_idx), .valid(s_valid));

   prio_enc_hi #(.N(STAGES), .IDX_W(STG_W)) u_flush_enc (
      .vec(flush_src), .idx(f_idx), .valid(f_valid));

   // Merge the latched flush with a new one; the older stage wins.
   always_comb begin
      e_valid = pend_valid | f_valid;
      if (pend_valid && f_valid) e_idx = (pend_idx > f_idx) ? pend_idx : f_idx;
      else if (pend_valid)       e_idx = pend_idx;
      else                       e_idx = f_idx;
      apply   = e_valid & bus.rdy & (~s_valid | (s_idx < e_idx));
      s_therm = thermo(int'(s_idx), STAGES);
      e_therm = thermo(int'(e_idx), STAGES);
   end

   always_comb begin
      if (!bus.rdy)       cur_state = HALT;
      else if (pend_valid) cur_state = DEFER;
      else if (s_valid)    cur_state = STALL;
      else                 cur_state = RUN;
   end

   always_comb begin
      pend_valid_nxt = pend_valid;
      pend_idx_nxt   = pend_idx;
      case (cur_state)
         HALT: begin
            if (e_valid) begin
               pend_valid_nxt = 1'b1;
               pend_idx_nxt   = e_idx;
            end
         end
         default: begin
            if (apply) begin
               pend_valid_nxt = 1'b0;
            end else if (e_valid) begin
               pend_valid_nxt = 1'b1;
               pend_idx_nxt   = e_idx;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_valid <= 1'b0;
         pend_idx   <= '0;
      end else begin
         pend_valid <= pend_valid_nxt;
         pend_idx   <= pend_idx_nxt;
      end
   end

   // Watchdog parks at TIMEOUT-1 once fired; the flag is sticky until reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt    <= '0;
         timeout_q <= 1'b0;
         cyc_q     <= '0;
      end else if (bus.rdy) begin
         if (s_valid) begin
            if (wd_cnt == WD_W'(TIMEOUT - 1)) timeout_q <= 1'b1;
            else                              wd_cnt    <= wd_cnt + WD_W'(1);
            if (cyc_q != '1) cyc_q <= cyc_q + CNT_W'(1);
         end else begin
            wd_cnt <= '0;
         end
      end
   end

   assign bus.stall = rst        ? '0 :
                      !bus.rdy   ? '1 :
                      s_valid    ? s_therm[STAGES-1:0] : '0;
   assign bus.flush = (!rst && apply) ? {e_therm[STAGES-1:1], 1'b0} : '0;
   assign bus.flush_pending = pend_valid;
   assign bus.stall_timeout = timeout_q;
   assign bus.stall_cycles  = cyc_q;

endmodule
